ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
- Instruction-fetch initiator; the requesting end of the instruction-memory PC-request / instruction-response ready/valid interface.
- Generates sequential PCs, issues them to instruction memory and pairs each returned instruction with its PC.
- Buffers fetched instructions for the decode stage.
- Handles redirects (branch/jump/trap) by flushing buffered and in-flight fetches.

Parameters:
- ADDR_WIDTH, 32, PC width.
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 4, fetch-buffer entries; also the maximum number of in-flight plus buffered fetches. Power of two, >= 2.

Ports:
- clk  in  1  clock
- async_rst_n  in  1  asynchronous active-low reset
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc
- redirect_pc  in  ADDR_WIDTH  new fetch address
- pc  out  ADDR_WIDTH  request address to instruction memory
- pc_valid_out  out  1  request valid
- pc_ready_in  in  1  instruction memory accepts the request
- instruction  in  DATA_WIDTH  response data
- instruction_valid_in  in  1  response valid
- instruction_ready_out  out  1  response accept
- dec_instr  out  DATA_WIDTH  instruction to decode
- dec_pc  out  ADDR_WIDTH  PC of dec_instr
- dec_valid_out  out  1  dec_instr/dec_pc valid
- dec_ready_in  in  1  decode consumes

Behaviour:
- Reset: clk, async_rst_n (asynchronous, active-low) as decided.
  - Fetch PC register = RESET_PC; buffer empty; discard counter 0.
  - pc_valid_out=0, dec_valid_out=0, dec_instr=0, dec_pc=0, instruction_ready_out=1.
  - Reset asserted mid-operation drops all state immediately. Responses arriving after reset release are not expected; the memory is reset on the same reset.
- Buffer: circular, DEPTH entries of {pc, instr, filled}.
  - Three pointers: alloc (tail), fill, head. Count = allocated entries.
- Issue:
  - pc = fetch PC register.
  - pc_valid_out = !redirect_valid && (count < DEPTH) && (discard == 0).
  - On pc_valid_out && pc_ready_in: allocate an entry at tail with pc, filled=0; fetch PC += 4 (modulo 2^ADDR_WIDTH, wraps silently).
  - Once asserted, pc_valid_out holds with a stable pc until handshake. Only exception: a redirect cycle deasserts it.
- Response:
  - instruction_ready_out is constant 1. This is legal because allocation reserves space.
  - On instruction_valid_in with discard==0: write instr into the entry at fill, set filled=1, advance fill.
  - On instruction_valid_in with discard>0: drop the data, decrement discard.
  - Responses are in order. A response with no outstanding request is a protocol error; assertion only in simulation.
- Output:
  - dec_valid_out = head entry allocated && filled; dec_instr/dec_pc come from the head entry (registered storage, combinational read).
  - On dec_valid_out && dec_ready_in: free head, advance head.
  - Allocate, fill and dequeue may all occur in the same cycle; count updates by (+alloc − dequeue).
  - Full (count==DEPTH): no issue. Empty: dec_valid_out=0.
- Redirect (redirect_valid=1, highest priority):
  - Fetch PC <= redirect_pc.
  - All buffer entries invalidated; pointers reset; count <= 0.
  - discard <= number of allocated-but-unfilled entries, minus 1 if a response arrives in that same cycle (that response is dropped).
  - No issue in the redirect cycle; no dequeue is reported to decode in that cycle (dec_valid_out forced 0).
  - Back-to-back redirects: the last one wins; discard accumulates correctly.
- Throughput: with 1-cycle-latency memory and decode always ready, one instruction per cycle after a 2-cycle start-up.
  - First dec_valid_out occurs 2 cycles after reset release.

Optional Feature:
- Macro: IFETCH_MISALIGN_CHECK_EN.
- Defined:
  - Adds output fetch_fault (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 sets fetch_fault; the flush still occurs.
  - While fetch_fault=1, pc_valid_out=0.
  - The next aligned redirect clears fetch_fault and resumes fetch.
- Undefined:
  - Port absent.
  - Low two bits of redirect_pc are forced to 0 when loaded.

Test Plan:
- Reset release, memory always ready, 1-cycle latency, decode ready -> PCs issued 0x0,0x4,0x8,...; dec_pc sequence 0x0,0x4,... one per cycle from cycle 2; dec_instr equals mem[pc>>2].
- Decode ready held 0 for 10 cycles -> exactly DEPTH=4 requests issued (0x0–0xC), then pc_valid_out=0; release -> 0x0..0xC delivered in order, fetch resumes at 0x10.
- Memory pc_ready_in toggles 1/0 every cycle -> pc stays stable while pc_valid_out=1 and not ready; no duplicated or skipped PCs at decode.
- Redirect to 0x100 while 2 requests are in flight and 1 is buffered -> next two responses dropped; dec_pc next shows 0x100, 0x104; no stale 0x0–0x8 entries delivered.
- Redirect coincident with a response and a dequeue -> that response is dropped, discard counts correctly, and the next dec_pc is redirect_pc.
- With IFETCH_MISALIGN_CHECK_EN: redirect 0x102 -> fetch_fault=1, no requests; redirect 0x200 -> fault clears, fetch resumes at 0x200.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction-fetch initiator: issues sequential PCs and buffers returned instructions for decode.
// Optional IFETCH_MISALIGN_CHECK_EN adds fetch_fault for misaligned redirect targets.
module ifetch_unit #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  async_rst_n,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  pc_valid_out,
    input  logic                  pc_ready_in,
    input  logic [DATA_WIDTH-1:0] instruction,
    input  logic                  instruction_valid_in,
    output logic                  instruction_ready_out,
    output logic [DATA_WIDTH-1:0] dec_instr,
    output logic [ADDR_WIDTH-1:0] dec_pc,
    output logic                  dec_valid_out,
    input  logic                  dec_ready_in
`ifdef IFETCH_MISALIGN_CHECK_EN
    ,
    output logic                  fetch_fault
`endif
);
    localparam int unsigned      PTR_W = $clog2(DEPTH);
    localparam int unsigned      CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]      alloc_q, alloc_d;
    logic [CNT_W-1:0]      fill_q, fill_d;
    logic [CNT_W-1:0]      head_q, head_d;
    logic [CNT_W-1:0]      discard_q, discard_d;
    logic [ADDR_WIDTH-1:0] pc_buf_q [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_buf_d [DEPTH];
    logic [DATA_WIDTH-1:0] ins_buf_q [DEPTH];
    logic [DATA_WIDTH-1:0] ins_buf_d [DEPTH];
    logic [DEPTH-1:0]      filled_q, filled_d;
    logic                  fault_q, fault_d;

    logic [CNT_W-1:0]      count, unfilled;
    logic [PTR_W-1:0]      alloc_idx, fill_idx, head_idx;
    logic                  issue, take, drop, deq;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic                  redirect_misaligned;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count     = alloc_q - head_q;
    assign unfilled  = alloc_q - fill_q;
    assign alloc_idx = alloc_q[PTR_W-1:0];
    assign fill_idx  = fill_q[PTR_W-1:0];
    assign head_idx  = head_q[PTR_W-1:0];

`ifdef IFETCH_MISALIGN_CHECK_EN
    assign redirect_target     = redirect_pc;
    assign redirect_misaligned = |redirect_pc[1:0];
    assign fetch_fault         = fault_q;
`else
    assign redirect_target     = redirect_pc & ~ADDR_WIDTH'(3);
    assign redirect_misaligned = 1'b0;
`endif

    assign instruction_ready_out = 1'b1;
    assign pc                    = fetch_pc_q;
    assign pc_valid_out          = async_rst_n && !redirect_valid
                                   && (count != FULL)
                                   && (discard_q == '0) && !fault_q;
    assign dec_valid_out         = !redirect_valid && (count != '0)
                                   && filled_q[head_idx];
    assign dec_pc                = pc_buf_q[head_idx];
    assign dec_instr             = ins_buf_q[head_idx];

    assign issue = pc_valid_out && pc_ready_in;
    assign take  = instruction_valid_in && (discard_q == '0);
    assign drop  = instruction_valid_in && (discard_q != '0);
    assign deq   = dec_valid_out && dec_ready_in;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        alloc_d    = alloc_q;
        fill_d     = fill_q;
        head_d     = head_q;
        discard_d  = discard_q;
        pc_buf_d   = pc_buf_q;
        ins_buf_d  = ins_buf_q;
        filled_d   = filled_q;
        fault_d    = fault_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
            fault_d    = redirect_misaligned;
            alloc_d    = '0;
            fill_d     = '0;
            head_d     = '0;
            filled_d   = '0;
            // Every request still owed by memory must be swallowed later.
            discard_d  = discard_q + unfilled
                         - CNT_W'(instruction_valid_in);
        end else begin
            if (issue) begin
                pc_buf_d[alloc_idx] = fetch_pc_q;
                filled_d[alloc_idx] = 1'b0;
                alloc_d             = alloc_q + ONE;
                fetch_pc_d          = fetch_pc_q + ADDR_WIDTH'(4);
            end
            if (take) begin
                ins_buf_d[fill_idx] = instruction;
                filled_d[fill_idx]  = 1'b1;
                fill_d              = fill_q + ONE;
            end
            if (drop) begin
                discard_d = discard_q - ONE;
            end
            if (deq) begin
                filled_d[head_idx] = 1'b0;
                head_d             = head_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            fetch_pc_q <= RESET_PC;
            alloc_q    <= '0;
            fill_q     <= '0;
            head_q     <= '0;
            discard_q  <= '0;
            filled_q   <= '0;
            fault_q    <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_buf_q[i]  <= '0;
                ins_buf_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            alloc_q    <= alloc_d;
            fill_q     <= fill_d;
            head_q     <= head_d;
            discard_q  <= discard_d;
            filled_q   <= filled_d;
            fault_q    <= fault_d;
            pc_buf_q   <= pc_buf_d;
            ins_buf_q  <= ins_buf_d;
        end
    end

    resp_has_owner: assert property (
        @(posedge clk) disable iff (!async_rst_n)
        instruction_valid_in |-> (discard_q != '0 || unfilled != '0));

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a 1..3-cycle-latency instruction memory model.
module tb_ifetch_unit;
    logic        clk = 1'b0;
    logic        async_rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] pc;
    logic        pc_valid_out;
    logic        pc_ready_in = 1'b1;
    logic [31:0] instruction;
    logic        instruction_valid_in;
    logic        instruction_ready_out;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_valid_out;
    logic        dec_ready_in = 1'b1;
`ifdef IFETCH_MISALIGN_CHECK_EN
    logic        fetch_fault;
`endif

    int total = 0;
    int bad = 0;
    int mem_lat = 1;
    logic [31:0] iq[$];
    logic [31:0] dq[$];
    logic [31:0] dqi[$];

    always #5 clk = ~clk;

    ifetch_unit dut (
        .clk                  (clk),
        .async_rst_n          (async_rst_n),
        .redirect_valid       (redirect_valid),
        .redirect_pc          (redirect_pc),
        .pc                   (pc),
        .pc_valid_out         (pc_valid_out),
        .pc_ready_in          (pc_ready_in),
        .instruction          (instruction),
        .instruction_valid_in (instruction_valid_in),
        .instruction_ready_out(instruction_ready_out),
        .dec_instr            (dec_instr),
        .dec_pc               (dec_pc),
        .dec_valid_out        (dec_valid_out),
        .dec_ready_in         (dec_ready_in)
`ifdef IFETCH_MISALIGN_CHECK_EN
        ,
        .fetch_fault          (fetch_fault)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory: fixed latency pipeline, response data = mem_word(pc).
    logic [2:0]  mv;
    logic [31:0] md [3];
    always @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            mv <= '0;
            md[0] <= '0;
            md[1] <= '0;
            md[2] <= '0;
        end else begin
            mv <= {mv[1:0], pc_valid_out && pc_ready_in};
            md[0] <= mem_word(pc);
            md[1] <= md[0];
            md[2] <= md[1];
        end
    end
    assign instruction_valid_in = mv[mem_lat-1];
    assign instruction = md[mem_lat-1];

    // Monitor: records handshakes mid-cycle, before the next posedge.
    always begin
        @(negedge clk);
        #3;
        if (async_rst_n) begin
            if (pc_valid_out && pc_ready_in) iq.push_back(pc);
            if (dec_valid_out && dec_ready_in) begin
                dq.push_back(dec_pc);
                dqi.push_back(dec_instr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input int lat);
        @(negedge clk);
        async_rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        pc_ready_in = 1'b1;
        dec_ready_in = 1'b1;
        mem_lat = lat;
        repeat (2) @(negedge clk);
        iq.delete();
        dq.delete();
        dqi.delete();
        async_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(1);
        #3;
        total++;
        if (pc !== 32'h0 || pc_valid_out !== 1'b1) begin
            bad++;
            $display("FAIL rst_first_req got pc=%h v=%b want pc=0 v=1", pc, pc_valid_out);
        end
        repeat (4) @(negedge clk);
        async_rst_n = 1'b0;
        #1;
        total++;
        if (pc_valid_out !== 1'b0) begin
            bad++;
            $display("FAIL rst_pcv got=%b want=0", pc_valid_out);
        end
        total++;
        if (dec_valid_out !== 1'b0) begin
            bad++;
            $display("FAIL rst_decv got=%b want=0", dec_valid_out);
        end
        total++;
        if (dec_pc !== 32'h0 || dec_instr !== 32'h0) begin
            bad++;
            $display("FAIL rst_dec got pc=%h ins=%h want 0", dec_pc, dec_instr);
        end
        total++;
        if (instruction_ready_out !== 1'b1) begin
            bad++;
            $display("FAIL rst_iready got=%b want=1", instruction_ready_out);
        end
        total++;
        if (pc !== 32'h0) begin
            bad++;
            $display("FAIL rst_pc got=%h want=0", pc);
        end
`ifdef IFETCH_MISALIGN_CHECK_EN
        total++;
        if (fetch_fault !== 1'b0) begin
            bad++;
            $display("FAIL rst_fault got=%b want=0", fetch_fault);
        end
`endif
        repeat (2) @(negedge clk);
        async_rst_n = 1'b1;
        #3;
        total++;
        if (pc !== 32'h0 || pc_valid_out !== 1'b1) begin
            bad++;
            $display("FAIL rst_release got pc=%h v=%b want pc=0 v=1", pc, pc_valid_out);
        end
    endtask

    task automatic test_stream();
        do_reset(1);
        #3;
        total++;
        if (dec_valid_out !== 1'b0) begin
            bad++;
            $display("FAIL stream_c0_decv got=%b want=0", dec_valid_out);
        end
        @(negedge clk);
        #3;
        total++;
        if (dec_valid_out !== 1'b0 || pc !== 32'h4) begin
            bad++;
            $display("FAIL stream_c1 got decv=%b pc=%h want decv=0 pc=4", dec_valid_out, pc);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #3;
            total++;
            if (dec_valid_out !== 1'b1 || dec_pc !== 32'(4 * k)) begin
                bad++;
                $display("FAIL stream_pc[%0d] got v=%b pc=%h want v=1 pc=%h", k, dec_valid_out, dec_pc, 32'(4 * k));
            end
            total++;
            if (dec_instr !== (32'hC0DE_0000 | 32'(4 * k))) begin
                bad++;
                $display("FAIL stream_ins[%0d] got=%h want=%h", k, dec_instr, 32'hC0DE_0000 | 32'(4 * k));
            end
        end
    endtask

    task automatic test_stall();
        do_reset(1);
        dec_ready_in = 1'b0;
        repeat (10) @(negedge clk);
        #3;
        total++;
        if (pc_valid_out !== 1'b0 || pc !== 32'h10) begin
            bad++;
            $display("FAIL stall_full got v=%b pc=%h want v=0 pc=10", pc_valid_out, pc);
        end
        total++;
        if (dec_valid_out !== 1'b1 || dec_pc !== 32'h0 || dec_instr !== 32'hC0DE_0000) begin
            bad++;
            $display("FAIL stall_head got v=%b pc=%h ins=%h want 1/0/c0de0000", dec_valid_out, dec_pc, dec_instr);
        end
        total++;
        if (iq.size() != 4 || dq.size() != 0) begin
            bad++;
            $display("FAIL stall_counts got issued=%0d deq=%0d want 4/0", iq.size(), dq.size());
        end
        @(negedge clk);
        dec_ready_in = 1'b1;
        repeat (10) @(negedge clk);
        #3;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (i >= dq.size() || dq[i] !== 32'(4 * i) || dqi[i] !== (32'hC0DE_0000 | 32'(4 * i))) begin
                bad++;
                $display("FAIL stall_deq[%0d] got=%h want=%h n=%0d", i, (i < dq.size()) ? dq[i] : 32'hx, 32'(4 * i), dq.size());
            end
        end
        total++;
        if (iq.size() < 5 || iq[4] !== 32'h10) begin
            bad++;
            $display("FAIL stall_resume got n=%0d want iq[4]=10", iq.size());
        end
    endtask

    task automatic test_toggle();
        do_reset(1);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            pc_ready_in = (k % 2 == 0);
            #3;
            total++;
            if (pc_valid_out !== 1'b1 || pc !== 32'(4 * ((k + 1) / 2))) begin
                bad++;
                $display("FAIL toggle_pc[%0d] got v=%b pc=%h want v=1 pc=%h", k, pc_valid_out, pc, 32'(4 * ((k + 1) / 2)));
            end
        end
        @(negedge clk);
        pc_ready_in = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        total++;
        if (iq.size() != 4 || dq.size() != 4) begin
            bad++;
            $display("FAIL toggle_counts got issued=%0d deq=%0d want 4/4", iq.size(), dq.size());
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= dq.size() || dq[i] !== 32'(4 * i)) begin
                bad++;
                $display("FAIL toggle_deq[%0d] got=%h want=%h", i, (i < dq.size()) ? dq[i] : 32'hx, 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect();
        do_reset(3);
        dec_ready_in = 1'b0;
        @(negedge clk);
        pc_ready_in = 1'b0;
        @(negedge clk);
        pc_ready_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        dec_ready_in = 1'b1;
        #3;
        total++;
        if (pc_valid_out !== 1'b0 || dec_valid_out !== 1'b0) begin
            bad++;
            $display("FAIL redir_cycle got pcv=%b decv=%b want 0/0", pc_valid_out, dec_valid_out);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        #3;
        total++;
        if (pc_valid_out !== 1'b0) begin
            bad++;
            $display("FAIL redir_discard1 got pcv=%b want=0", pc_valid_out);
        end
        @(negedge clk);
        #3;
        total++;
        if (pc_valid_out !== 1'b0) begin
            bad++;
            $display("FAIL redir_discard2 got pcv=%b want=0", pc_valid_out);
        end
        @(negedge clk);
        #3;
        total++;
        if (pc_valid_out !== 1'b1 || pc !== 32'h100) begin
            bad++;
            $display("FAIL redir_resume got v=%b pc=%h want v=1 pc=100", pc_valid_out, pc);
        end
        repeat (8) @(negedge clk);
        #3;
        total++;
        if (dq.size() < 2 || dq[0] !== 32'h100 || dq[1] !== 32'h104) begin
            bad++;
            $display("FAIL redir_deq got n=%0d first=%h want 100,104", dq.size(), (dq.size() > 0) ? dq[0] : 32'hx);
        end
        total++;
        if (dqi.size() < 1 || dqi[0] !== 32'hC0DE_0100) begin
            bad++;
            $display("FAIL redir_ins got n=%0d want c0de0100", dqi.size());
        end
        total++;
        if (iq.size() < 4 || iq[3] !== 32'h100) begin
            bad++;
            $display("FAIL redir_issue got n=%0d want iq[3]=100", iq.size());
        end
    endtask

    task automatic test_coincident();
        do_reset(1);
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        #3;
        total++;
        if (dec_valid_out !== 1'b0 || pc_valid_out !== 1'b0) begin
            bad++;
            $display("FAIL coin_cycle got decv=%b pcv=%b want 0/0", dec_valid_out, pc_valid_out);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        #3;
        total++;
        if (pc_valid_out !== 1'b1 || pc !== 32'h200) begin
            bad++;
            $display("FAIL coin_resume got v=%b pc=%h want v=1 pc=200", pc_valid_out, pc);
        end
        repeat (2) @(negedge clk);
        #3;
        total++;
        if (dec_valid_out !== 1'b1 || dec_pc !== 32'h200 || dec_instr !== 32'hC0DE_0200) begin
            bad++;
            $display("FAIL coin_dec got v=%b pc=%h ins=%h want 1/200/c0de0200", dec_valid_out, dec_pc, dec_instr);
        end
        repeat (2) @(negedge clk);
        #3;
        total++;
        if (dq.size() < 2 || dq[0] !== 32'h0 || dq[1] !== 32'h200) begin
            bad++;
            $display("FAIL coin_deq got n=%0d second=%h want 0,200", dq.size(), (dq.size() > 1) ? dq[1] : 32'hx);
        end
    endtask

    task automatic test_back_to_back();
        do_reset(2);
        repeat (4) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        @(negedge clk);
        redirect_pc = 32'h400;
        #3;
        total++;
        if (pc_valid_out !== 1'b0) begin
            bad++;
            $display("FAIL b2b_cycle got pcv=%b want=0", pc_valid_out);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        #3;
        total++;
        if (pc_valid_out !== 1'b1 || pc !== 32'h400) begin
            bad++;
            $display("FAIL b2b_resume got v=%b pc=%h want v=1 pc=400", pc_valid_out, pc);
        end
        repeat (6) @(negedge clk);
        #3;
        total++;
        if (dq.size() < 3 || dq[0] !== 32'h0 || dq[1] !== 32'h400 || dq[2] !== 32'h404) begin
            bad++;
            $display("FAIL b2b_deq got n=%0d second=%h want 0,400,404", dq.size(), (dq.size() > 1) ? dq[1] : 32'hx);
        end
        total++;
        if (iq.size() < 5 || iq[4] !== 32'h400) begin
            bad++;
            $display("FAIL b2b_issue got n=%0d want iq[4]=400", iq.size());
        end
    endtask

    task automatic test_wrap();
        do_reset(1);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        #3;
        total++;
        if (pc_valid_out !== 1'b1 || pc !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL wrap_top got v=%b pc=%h want v=1 pc=fffffffc", pc_valid_out, pc);
        end
        @(negedge clk);
        #3;
        total++;
        if (pc !== 32'h0) begin
            bad++;
            $display("FAIL wrap_zero got=%h want=0", pc);
        end
        repeat (4) @(negedge clk);
        #3;
        total++;
        if (dq.size() < 2 || dq[0] !== 32'hFFFF_FFFC || dq[1] !== 32'h0 || dqi[0] !== 32'h3F21_FFFC) begin
            bad++;
            $display("FAIL wrap_deq got n=%0d first=%h want fffffffc,0", dq.size(), (dq.size() > 0) ? dq[0] : 32'hx);
        end
    endtask

`ifdef IFETCH_MISALIGN_CHECK_EN
    task automatic test_misalign();
        do_reset(1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h102;
        @(negedge clk);
        redirect_valid = 1'b0;
        #3;
        total++;
        if (fetch_fault !== 1'b1 || pc_valid_out !== 1'b0) begin
            bad++;
            $display("FAIL fault_set got f=%b v=%b want 1/0", fetch_fault, pc_valid_out);
        end
        repeat (3) @(negedge clk);
        #3;
        total++;
        if (pc_valid_out !== 1'b0 || iq.size() != 0) begin
            bad++;
            $display("FAIL fault_hold got v=%b n=%0d want 0/0", pc_valid_out, iq.size());
        end
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        @(negedge clk);
        redirect_valid = 1'b0;
        #3;
        total++;
        if (fetch_fault !== 1'b0 || pc_valid_out !== 1'b1 || pc !== 32'h200) begin
            bad++;
            $display("FAIL fault_clear got f=%b v=%b pc=%h want 0/1/200", fetch_fault, pc_valid_out, pc);
        end
        repeat (4) @(negedge clk);
        #3;
        total++;
        if (dq.size() < 1 || dq[0] !== 32'h200) begin
            bad++;
            $display("FAIL fault_deq got n=%0d want first=200", dq.size());
        end
    endtask
`else
    task automatic test_misalign();
        do_reset(1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h10B;
        @(negedge clk);
        redirect_valid = 1'b0;
        #3;
        total++;
        if (pc_valid_out !== 1'b1 || pc !== 32'h108) begin
            bad++;
            $display("FAIL mask_pc got v=%b pc=%h want v=1 pc=108", pc_valid_out, pc);
        end
        repeat (4) @(negedge clk);
        #3;
        total++;
        if (dq.size() < 1 || dq[0] !== 32'h108 || dqi[0] !== 32'hC0DE_0108) begin
            bad++;
            $display("FAIL mask_deq got n=%0d want first=108", dq.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_toggle();
        test_redirect();
        test_coincident();
        test_back_to_back();
        test_wrap();
        test_misalign();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
